// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen_pkg
//  Description : Shared constants, channel-state view and divisor helper for
//                the multi-rate tick generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package tick_gen_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
    localparam int unsigned TG_CNT_W       = 32;

    // Snapshot of one channel's architectural state at the default width.
    typedef struct packed {
        logic [TG_CNT_W-1:0] cnt;
        logic [TG_CNT_W-1:0] half;
        logic [TG_CNT_W-1:0] shadow;
        logic                pend;
        logic                out_clk;
    } tick_chan_state_t;

    // Half-period in clk cycles for a target output frequency, never below 1.
    function automatic int unsigned half_for_hz(input int unsigned clk_hz,
                                                input int unsigned hz);
        int unsigned h;
        if (hz == 0) begin
            h = 1;
        end else begin
            h = clk_hz / (2 * hz);
        end
        if (h == 0) begin
            h = 1;
        end
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen_channel
//  Description : One tick-generator channel: half-period counter, shadowed
//                divisor reload at wrap boundaries, square-wave toggle and
//                rise tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = 50_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] val,
    output logic             out_clk,
    output logic             tick
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEF = (DEFAULT_HALF == 0) ? C_ONE : CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] val_clamp;
    logic             wrap;

    assign val_clamp = (val == '0) ? C_ONE : val;
    assign wrap      = (cnt_q == (half_q - C_ONE));

    // Next-state: sync > disable > arm > wrap/count, then divisor write.
    // run_q marks that the arming edge (cnt held at 0) has been taken, so the
    // first rise lands exactly H edges after en is first seen high.
    always_comb begin
        cnt_d    = cnt_q;
        half_d   = half_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        run_d    = run_q;
        out_d    = out_q;
        tick_d   = 1'b0;

        if (sync) begin
            cnt_d = '0;
            out_d = 1'b0;
            run_d = en;
            if (pend_q) begin
                half_d = shadow_q;
                pend_d = 1'b0;
            end
        end else if (!en) begin
            cnt_d = '0;
            out_d = 1'b0;
            run_d = 1'b0;
        end else if (!run_q) begin
            cnt_d = '0;
            out_d = 1'b0;
            run_d = 1'b1;
        end else if (wrap) begin
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = ~out_q;
            if (pend_q) begin
                half_d = shadow_q;
                pend_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + C_ONE;
        end

        // A running channel defers the new divisor to the next wrap so the
        // in-flight half-period never shortens; an idle one takes it at once.
        if (we) begin
            if (en) begin
                shadow_d = val_clamp;
                pend_d   = 1'b1;
            end else begin
                half_d = val_clamp;
                pend_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset to the default divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            half_q   <= C_DEF;
            shadow_q <= C_DEF;
            pend_q   <= 1'b0;
            run_q    <= 1'b0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            run_q    <= run_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
        end
    end

    assign out_clk = out_q;
    assign tick    = tick_q;

endmodule
`default_nettype wire

// File: rtl/multi_rate_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : multi_rate_tick_gen
//  Description : N-channel programmable square-wave / tick generator with
//                per-channel enables, glitch-free divisor reload and global
//                phase alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_rate_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = half_for_hz(CLK_HZ, 1000),
    localparam int unsigned SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             div_we,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [CNT_W-1:0] div_val,
    output logic [N_CH-1:0]  out_clk,
    output logic [N_CH-1:0]  tick
);

    logic [N_CH-1:0] w_we;

    // One channel per index; a select value with no matching channel
    // decodes to no write strobe and is therefore ignored.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_we[i] = div_we && (div_sel == SEL_W'(i));

        tick_gen_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .we      (w_we[i]),
            .val     (div_val),
            .out_clk (out_clk[i]),
            .tick    (tick[i])
        );
    end

endmodule
`default_nettype wire
